// File: rtl/tetris_pkg.sv
// Shared field geometry, field/row types and the line-clear FSM encoding.
package tetris_pkg;

    localparam int unsigned ROW_CNT     = 20;
    localparam int unsigned COL_CNT     = 10;
    localparam int unsigned COLOR_W     = 3;
    localparam int unsigned FLASH_TICKS = 6;

    localparam int unsigned FIELD_W = ROW_CNT * COL_CNT * COLOR_W;
    localparam int unsigned LINE_W  = $clog2(ROW_CNT + 1);
    localparam int unsigned ROW_W   = $clog2(ROW_CNT);
    localparam int unsigned TICK_W  = $clog2(FLASH_TICKS + 1);

    typedef logic [COLOR_W-1:0] color_t;
    typedef color_t [COL_CNT-1:0] row_t;
    typedef row_t [ROW_CNT-1:0] field_t;
    typedef logic [ROW_CNT-1:0] row_mask_t;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        FLASH,
        COLLAPSE,
        FILL,
        DONE
    } state_t;

endpackage

// File: rtl/field_line_clear_ctrl_if.sv
// Game-logic / renderer handshake with the line-clear controller.
interface field_line_clear_ctrl_if;
    import tetris_pkg::*;

    logic      frame_tick_i;
    logic      start_i;
    field_t    field_i;
    logic      busy_o;
    logic      done_o;
    field_t    field_o;
    logic [LINE_W-1:0] lines_o;
    row_mask_t flash_mask_o;
    logic      flash_on_o;

    modport master (
        output frame_tick_i, start_i, field_i,
        input  busy_o, done_o, field_o, lines_o, flash_mask_o, flash_on_o
    );

    modport slave (
        input  frame_tick_i, start_i, field_i,
        output busy_o, done_o, field_o, lines_o, flash_mask_o, flash_on_o
    );

endinterface

// File: rtl/row_full_det.sv
// Flags a field row whose every cell holds a brick.
module row_full_det
    import tetris_pkg::*;
(
    input  row_t row,
    output logic full_c
);

    always_comb begin
        full_c = 1'b1;
        for (int unsigned c = 0; c < COL_CNT; c++) begin
            if (row[c] == '0) begin
                full_c = 1'b0;
            end
        end
    end

endmodule

// File: rtl/field_line_clear_ctrl.sv
// Scans a locked field for full rows, flashes them, then collapses the field downward.
module field_line_clear_ctrl
    import tetris_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    field_line_clear_ctrl_if.slave bus
);

    state_t            state_q, state_d;
    field_t            field_q, field_d;
    logic [LINE_W-1:0] lines_q, lines_d;
    row_mask_t         mask_q, mask_d;
    row_mask_t         flash_mask_q, flash_mask_d;
    logic              flash_on_q, flash_on_d;
    logic [ROW_W-1:0]  rd_q, rd_d;
    logic [ROW_W-1:0]  wr_q, wr_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              row_full_c;

    row_full_det u_row_full_det (
        .row    (field_q[rd_q]),
        .full_c (row_full_c)
    );

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            field_q      <= '0;
            lines_q      <= '0;
            mask_q       <= '0;
            flash_mask_q <= '0;
            flash_on_q   <= 1'b0;
            rd_q         <= '0;
            wr_q         <= '0;
            tick_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            field_q      <= field_d;
            lines_q      <= lines_d;
            mask_q       <= mask_d;
            flash_mask_q <= flash_mask_d;
            flash_on_q   <= flash_on_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            tick_q       <= tick_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        field_d      = field_q;
        lines_d      = lines_q;
        mask_d       = mask_q;
        flash_mask_d = flash_mask_q;
        flash_on_d   = flash_on_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        tick_d       = tick_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d      = SCAN;
                    field_d      = bus.field_i;
                    lines_d      = '0;
                    mask_d       = '0;
                    flash_mask_d = '0;
                    flash_on_d   = 1'b0;
                    rd_d         = ROW_W'(ROW_CNT - 1);
                    busy_d       = 1'b1;
                end
            end

            SCAN: begin
                if (row_full_c) begin
                    mask_d[rd_q] = 1'b1;
                    lines_d      = lines_q + LINE_W'(1);
                end
                if (rd_q == '0) begin
                    if (mask_d == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d      = FLASH;
                        flash_mask_d = mask_d;
                        flash_on_d   = 1'b1;
                        tick_d       = '0;
                    end
                end else begin
                    rd_d = rd_q - ROW_W'(1);
                end
            end

            FLASH: begin
                if (bus.frame_tick_i) begin
                    if (tick_q == TICK_W'(FLASH_TICKS - 1)) begin
                        state_d      = COLLAPSE;
                        flash_on_d   = 1'b0;
                        flash_mask_d = '0;
                        rd_d         = ROW_W'(ROW_CNT - 1);
                        wr_d         = ROW_W'(ROW_CNT - 1);
                    end else begin
                        flash_on_d = ~flash_on_q;
                        tick_d     = tick_q + TICK_W'(1);
                    end
                end
            end

            // Snapshot mask drives the collapse; rows at or above rd are still untouched
            COLLAPSE: begin
                if (!mask_q[rd_q]) begin
                    field_d[wr_q] = field_q[rd_q];
                    wr_d          = wr_q - ROW_W'(1);
                end
                if (rd_q == '0) begin
                    state_d = FILL;
                end else begin
                    rd_d = rd_q - ROW_W'(1);
                end
            end

            FILL: begin
                field_d[wr_q] = '0;
                if (wr_q == '0) begin
                    state_d = DONE;
                end else begin
                    wr_d = wr_q - ROW_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.field_o      = field_q;
    assign bus.lines_o      = lines_q;
    assign bus.flash_mask_o = flash_mask_q;
    assign bus.flash_on_o   = flash_on_q;

endmodule

// File: tb/tb_field_line_clear_ctrl.sv
// Randomized bench for field_line_clear_ctrl against a row-filtering reference model.
module tb_field_line_clear_ctrl;
    import tetris_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    field_line_clear_ctrl_if bus();

    field_line_clear_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [FIELD_W-1:0] got,
                         input logic [FIELD_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: drop full rows, keep the survivors in order at the bottom, pad top with empty rows
    function automatic void model(input field_t f, output field_t res, output int lines,
                                  output row_mask_t mask);
        row_t keep[$];
        bit   full;
        res   = '0;
        lines = 0;
        mask  = '0;
        for (int r = ROW_CNT - 1; r >= 0; r--) begin
            full = 1'b1;
            for (int c = 0; c < COL_CNT; c++) if (f[r][c] == '0) full = 1'b0;
            if (full) begin
                mask[r] = 1'b1;
                lines++;
            end else begin
                keep.push_back(f[r]);
            end
        end
        for (int i = 0; i < keep.size(); i++) res[ROW_CNT - 1 - i] = keep[i];
    endfunction

    function automatic field_t rand_field(input row_mask_t full_rows, input int pct);
        field_t f = '0;
        for (int r = 0; r < ROW_CNT; r++) begin
            for (int c = 0; c < COL_CNT; c++) begin
                if (full_rows[r] || int'($urandom_range(0, 99)) < pct)
                    f[r][c] = COLOR_W'($urandom_range(1, (1 << COLOR_W) - 1));
            end
            if (!full_rows[r]) f[r][$urandom_range(0, COL_CNT - 1)] = '0;
        end
        return f;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, FIELD_W'(bus.busy_o), '0);
        check({tag, "_done"}, FIELD_W'(bus.done_o), '0);
        check({tag, "_field"}, bus.field_o, '0);
        check({tag, "_lines"}, FIELD_W'(bus.lines_o), '0);
        check({tag, "_mask"}, FIELD_W'(bus.flash_mask_o), '0);
        check({tag, "_flash_on"}, FIELD_W'(bus.flash_on_o), '0);
    endtask

    // One clear operation; optional stray starts while busy, optional reset at cycle rst_at
    task automatic run_op(input field_t f, input bit extra_start, input int rst_at);
        field_t    exp_res;
        int        exp_lines, cyc, ticks, coll_start, exp_done;
        row_mask_t exp_mask;
        bit        in_flash, got_done, tk;

        model(f, exp_res, exp_lines, exp_mask);
        bus.field_i = f;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        check("busy_after_start", FIELD_W'(bus.busy_o), FIELD_W'(1));
        check("load_field", bus.field_o, f);

        cyc = 0; ticks = 0; coll_start = -1; in_flash = 0; got_done = 0;
        while (!got_done && cyc < 400) begin
            tk = ($urandom_range(0, 2) == 0);
            bus.frame_tick_i = tk;
            if (extra_start && cyc < ROW_CNT - 1) begin
                bus.start_i = 1'($urandom_range(0, 1));
                bus.field_i = rand_field(row_mask_t'($urandom), 50);
            end
            if (rst_at == cyc) rst = 1'b1;
            step();
            cyc++;
            bus.start_i      = 1'b0;
            bus.frame_tick_i = 1'b0;

            if (rst) begin
                check_outputs_zero("rst_mid_op");
                rst = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    step();
                    check("no_done_after_rst", FIELD_W'(bus.done_o), '0);
                    check("idle_after_rst", FIELD_W'(bus.busy_o), '0);
                end
                return;
            end

            if (in_flash && tk) ticks++;
            if (!in_flash && coll_start < 0 && exp_lines > 0 && cyc == ROW_CNT) in_flash = 1;
            if (in_flash && ticks == FLASH_TICKS) begin
                in_flash   = 0;
                coll_start = cyc;
            end
            check("flash_on", FIELD_W'(bus.flash_on_o), FIELD_W'(in_flash && (ticks % 2 == 0)));
            check("flash_mask", FIELD_W'(bus.flash_mask_o), in_flash ? FIELD_W'(exp_mask) : '0);

            if (exp_lines == 0) exp_done = ROW_CNT + 1;
            else if (coll_start < 0) exp_done = -1;
            else exp_done = coll_start + ROW_CNT + exp_lines + 1;

            if (bus.done_o) begin
                got_done = 1;
                check("done_cycle", FIELD_W'(cyc), FIELD_W'(exp_done));
                check("lines", FIELD_W'(bus.lines_o), FIELD_W'(exp_lines));
                check("result_field", bus.field_o, exp_res);
                check("busy_at_done", FIELD_W'(bus.busy_o), '0);
            end else begin
                check("busy_during_op", FIELD_W'(bus.busy_o), FIELD_W'(1));
            end
        end

        if (!got_done) begin
            check("done_timeout", '0, FIELD_W'(1));
        end else begin
            step();
            check("done_one_cycle", FIELD_W'(bus.done_o), '0);
            check("hold_field", bus.field_o, exp_res);
            check("hold_lines", FIELD_W'(bus.lines_o), FIELD_W'(exp_lines));
        end
    endtask

    initial begin
        field_t f;
        rst              = 1'b1;
        bus.start_i      = 1'b0;
        bus.frame_tick_i = 1'b0;
        bus.field_i      = '0;
        repeat (3) step();
        check_outputs_zero("reset");
        rst = 1'b0;
        step();

        // Empty field
        run_op('0, 0, -1);
        // Sparse field, no full rows
        run_op(rand_field('0, 60), 0, -1);

        // Bottom row full plus a lone brick above it
        f = '0;
        for (int c = 0; c < COL_CNT; c++) f[ROW_CNT - 1][c] = COLOR_W'(3);
        f[ROW_CNT - 2][0] = COLOR_W'(5);
        run_op(f, 0, -1);

        // Rows 19, 17, 16, 14 full
        run_op(rand_field(row_mask_t'((1 << 19) | (1 << 17) | (1 << 16) | (1 << 14)), 40), 0, -1);

        // Every row full
        run_op(rand_field('1, 0), 0, -1);

        // Reset during the flash phase, then a normal operation
        run_op(rand_field(row_mask_t'((1 << 19) | (1 << 5)), 50), 0, ROW_CNT + 2);
        run_op(rand_field(row_mask_t'((1 << 10)), 50), 0, -1);

        // Stray starts while busy
        run_op(rand_field(row_mask_t'((1 << 19) | (1 << 17) | (1 << 16) | (1 << 14)), 40), 1, -1);
        run_op('0, 1, -1);

        // Random fields
        for (int n = 0; n < 12; n++) begin
            row_mask_t fr = '0;
            for (int r = 0; r < ROW_CNT; r++) fr[r] = ($urandom_range(0, 3) == 0);
            run_op(rand_field(fr, int'($urandom_range(0, 90))), 1'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
